// File: rtl/spi_port_arbiter.sv
// spi_port_arbiter: shares one SPI mode-0, MSB-first byte engine between two requesters
// (0 = cart-bus register path, 1 = background/boot loader). The engine drives either the
// flash port or the TF card port. Arbitration is round-robin, and the bus stays locked for
// the whole chip-select transaction.
//
// Ports
//   FastClk, Reset                  clock, asynchronous active-high reset
//   ReqN_Valid/Dev/TxData/Last      byte request (N = 0, 1); Dev is used on the first byte only
//   ReqN_Ready                      request accepted when Valid & Ready
//   RespN_Valid/RxData              one-cycle completion pulse and received byte (held)
//   nFlashSel/SPIClk/SPIDo/SPIDi    flash SPI pins
//   nTFSel/TFClk/TFDo/TFDi          TF card SPI pins
//   Busy                            engine not idle
module spi_port_arbiter #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       FastClk,
  input  logic       Reset,
  input  logic       Req0_Valid,
  input  logic       Req0_Dev,
  input  logic [7:0] Req0_TxData,
  input  logic       Req0_Last,
  output logic       Req0_Ready,
  output logic       Resp0_Valid,
  output logic [7:0] Resp0_RxData,
  input  logic       Req1_Valid,
  input  logic       Req1_Dev,
  input  logic [7:0] Req1_TxData,
  input  logic       Req1_Last,
  output logic       Req1_Ready,
  output logic       Resp1_Valid,
  output logic [7:0] Resp1_RxData,
  output logic       nFlashSel,
  output logic       SPIClk,
  output logic       SPIDo,
  input  logic       SPIDi,
  output logic       nTFSel,
  output logic       TFClk,
  output logic       TFDo,
  input  logic       TFDi,
  output logic       Busy
);

  localparam int unsigned CntW = $clog2(2 * CLK_DIV + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StShift, StHold, StTail, StGap} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            dev_q, dev_d;
  logic            last_grant_q, last_grant_d;
  logic            last_byte_q, last_byte_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      rdata0_q, rdata0_d;
  logic [7:0]      rdata1_q, rdata1_d;
  logic            sck_q, sck_d;
  logic [2:0]      bit_q, bit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      resp_q, resp_d;

  logic       ready0, ready1;
  logic       accept, acc_req;
  logic       half_end;
  logic       miso;
  logic       cs_active;

  assign half_end = (cnt_q == CntMax);
  assign miso     = dev_q ? TFDi : SPIDi;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    dev_d        = dev_q;
    last_grant_d = last_grant_q;
    last_byte_d  = last_byte_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    sck_d        = sck_q;
    bit_d        = bit_q;
    cnt_d        = cnt_q;
    resp_d       = 2'b00;
    ready0       = 1'b0;
    ready1       = 1'b0;
    accept       = 1'b0;
    acc_req      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // last_grant_q names the requester granted most recently; the other one wins a tie.
        if (Req0_Valid && (!Req1_Valid || last_grant_q)) begin
          ready0  = 1'b1;
          accept  = 1'b1;
          acc_req = 1'b0;
        end else if (Req1_Valid) begin
          ready1  = 1'b1;
          accept  = 1'b1;
          acc_req = 1'b1;
        end
        if (accept) begin
          owner_d      = acc_req;
          last_grant_d = acc_req;
          dev_d        = acc_req ? Req1_Dev : Req0_Dev;
        end
      end
      StHold: begin
        // Bus locked: only the owner may continue the transaction.
        ready0  = ~owner_q;
        ready1  = owner_q;
        acc_req = owner_q;
        accept  = owner_q ? Req1_Valid : Req0_Valid;
      end
      StShift: begin
        cnt_d = cnt_q + CntW'(1);
        if (half_end) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[6:0], miso};
          end else if (bit_q == 3'd7) begin
            // Final falling edge: byte done, MOSI keeps bit 0.
            bit_d = 3'd0;
            if (owner_q) begin
              resp_d[1] = 1'b1;
              rdata1_d  = rx_q;
            end else begin
              resp_d[0] = 1'b1;
              rdata0_d  = rx_q;
            end
            state_d = last_byte_q ? StTail : StHold;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = {tx_q[6:0], 1'b1};
          end
        end
      end
      StTail: begin
        cnt_d = cnt_q + CntW'(1);
        if (half_end) begin
          cnt_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        cnt_d = cnt_q + CntW'(1);
        if (half_end) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      tx_d        = acc_req ? Req1_TxData : Req0_TxData;
      last_byte_d = acc_req ? Req1_Last : Req0_Last;
      state_d     = StShift;
      cnt_d       = '0;
      sck_d       = 1'b0;
      bit_d       = 3'd0;
    end
  end

  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      dev_q        <= 1'b0;
      last_grant_q <= 1'b1;
      last_byte_q  <= 1'b0;
      tx_q         <= 8'h00;
      rx_q         <= 8'h00;
      rdata0_q     <= 8'h00;
      rdata1_q     <= 8'h00;
      sck_q        <= 1'b0;
      bit_q        <= 3'd0;
      cnt_q        <= '0;
      resp_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      dev_q        <= dev_d;
      last_grant_q <= last_grant_d;
      last_byte_q  <= last_byte_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      sck_q        <= sck_d;
      bit_q        <= bit_d;
      cnt_q        <= cnt_d;
      resp_q       <= resp_d;
    end
  end

  // Pins decode straight from state so an asynchronous reset idles them immediately.
  assign cs_active = (state_q == StShift) || (state_q == StHold) || (state_q == StTail);

  assign nFlashSel = ~(cs_active && !dev_q);
  assign SPIClk    = (state_q == StShift) && !dev_q && sck_q;
  assign SPIDo     = (cs_active && !dev_q) ? tx_q[7] : 1'b1;
  assign nTFSel    = ~(cs_active && dev_q);
  assign TFClk     = (state_q == StShift) && dev_q && sck_q;
  assign TFDo      = (cs_active && dev_q) ? tx_q[7] : 1'b1;

  assign Req0_Ready   = ready0;
  assign Req1_Ready   = ready1;
  assign Resp0_Valid  = resp_q[0];
  assign Resp1_Valid  = resp_q[1];
  assign Resp0_RxData = rdata0_q;
  assign Resp1_RxData = rdata1_q;
  assign Busy         = (state_q != StIdle);

endmodule

// File: tb/tb_spi_port_arbiter.sv
module tb_spi_port_arbiter;

  logic       FastClk = 1'b0;
  logic       Reset   = 1'b1;
  logic       Req0_Valid = 1'b0, Req0_Dev = 1'b0, Req0_Last = 1'b0;
  logic [7:0] Req0_TxData = 8'h00;
  logic       Req1_Valid = 1'b0, Req1_Dev = 1'b0, Req1_Last = 1'b0;
  logic [7:0] Req1_TxData = 8'h00;
  logic       Req0_Ready, Resp0_Valid, Req1_Ready, Resp1_Valid;
  logic [7:0] Resp0_RxData, Resp1_RxData;
  logic       nFlashSel, SPIClk, SPIDo, nTFSel, TFClk, TFDo, Busy;
  logic       SPIDi = 1'b1, TFDi = 1'b1;

  // Second instance with CLK_DIV = 1.
  logic       d1_Req0_Valid = 1'b0;
  logic [7:0] d1_Req0_TxData = 8'h00;
  logic       d1_Req0_Ready, d1_Resp0_Valid, d1_Req1_Ready, d1_Resp1_Valid;
  logic [7:0] d1_Resp0_RxData, d1_Resp1_RxData;
  logic       d1_nFlashSel, d1_SPIClk, d1_SPIDo, d1_nTFSel, d1_TFClk, d1_TFDo, d1_Busy;
  logic       d1_SPIDi = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] sb[$];  // {requester, expected byte}

  logic [7:0] fl_byte = 8'h3C, tf_byte = 8'h5A, d1_byte = 8'hC3;
  int fl_idx = 0, tf_idx = 0, d1_idx = 0;

  always #5 FastClk = ~FastClk;

  spi_port_arbiter #(.CLK_DIV(2)) dut (
    .FastClk(FastClk), .Reset(Reset),
    .Req0_Valid(Req0_Valid), .Req0_Dev(Req0_Dev), .Req0_TxData(Req0_TxData),
    .Req0_Last(Req0_Last), .Req0_Ready(Req0_Ready), .Resp0_Valid(Resp0_Valid),
    .Resp0_RxData(Resp0_RxData),
    .Req1_Valid(Req1_Valid), .Req1_Dev(Req1_Dev), .Req1_TxData(Req1_TxData),
    .Req1_Last(Req1_Last), .Req1_Ready(Req1_Ready), .Resp1_Valid(Resp1_Valid),
    .Resp1_RxData(Resp1_RxData),
    .nFlashSel(nFlashSel), .SPIClk(SPIClk), .SPIDo(SPIDo), .SPIDi(SPIDi),
    .nTFSel(nTFSel), .TFClk(TFClk), .TFDo(TFDo), .TFDi(TFDi), .Busy(Busy)
  );

  spi_port_arbiter #(.CLK_DIV(1)) dut1 (
    .FastClk(FastClk), .Reset(Reset),
    .Req0_Valid(d1_Req0_Valid), .Req0_Dev(1'b0), .Req0_TxData(d1_Req0_TxData),
    .Req0_Last(1'b1), .Req0_Ready(d1_Req0_Ready), .Resp0_Valid(d1_Resp0_Valid),
    .Resp0_RxData(d1_Resp0_RxData),
    .Req1_Valid(1'b0), .Req1_Dev(1'b0), .Req1_TxData(8'h00),
    .Req1_Last(1'b0), .Req1_Ready(d1_Req1_Ready), .Resp1_Valid(d1_Resp1_Valid),
    .Resp1_RxData(d1_Resp1_RxData),
    .nFlashSel(d1_nFlashSel), .SPIClk(d1_SPIClk), .SPIDo(d1_SPIDo), .SPIDi(d1_SPIDi),
    .nTFSel(d1_nTFSel), .TFClk(d1_TFClk), .TFDo(d1_TFDo), .TFDi(1'b1), .Busy(d1_Busy)
  );

  // Mode-0 slave models: first bit on CS fall, next bit after each SCK fall.
  always @(negedge nFlashSel) begin
    fl_idx = 0;
    SPIDi  = fl_byte[7];
  end
  always @(negedge SPIClk) if (!nFlashSel) begin
    fl_idx = (fl_idx + 1) % 8;
    SPIDi  = fl_byte[7-fl_idx];
  end
  always @(negedge nTFSel) begin
    tf_idx = 0;
    TFDi   = tf_byte[7];
  end
  // TF model returns a different byte each time (+0x11) so burst bytes are distinguishable.
  always @(negedge TFClk) if (!nTFSel) begin
    tf_idx = tf_idx + 1;
    if (tf_idx == 8) begin
      tf_idx  = 0;
      tf_byte = tf_byte + 8'h11;
    end
    TFDi = tf_byte[7-tf_idx];
  end
  always @(negedge d1_nFlashSel) begin
    d1_idx   = 0;
    d1_SPIDi = d1_byte[7];
  end
  always @(negedge d1_SPIClk) if (!d1_nFlashSel) begin
    d1_idx   = (d1_idx + 1) % 8;
    d1_SPIDi = d1_byte[7-d1_idx];
  end

  // Waits (bounded) for a response pulse from the main instance; cyc counts negedges.
  task automatic wait_resp(input int max_cyc, output bit got, output logic [8:0] obs,
                           output int cyc);
    got = 1'b0;
    cyc = 0;
    obs = 'x;
    while (!got && cyc < max_cyc) begin
      @(negedge FastClk);
      cyc++;
      if (Resp0_Valid || Resp1_Valid) begin
        got = 1'b1;
        obs = {Resp1_Valid, Resp1_Valid ? Resp1_RxData : Resp0_RxData};
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge FastClk);
    n_checks++;
    if ({nFlashSel, nTFSel, SPIClk, TFClk, SPIDo, TFDo, Busy, Resp0_Valid, Resp1_Valid,
         Req0_Ready, Req1_Ready} !== 11'b11001100000) begin
      n_fail++;
      $display("FAIL reset_pins: got %b expected %b",
               {nFlashSel, nTFSel, SPIClk, TFClk, SPIDo, TFDo, Busy, Resp0_Valid,
                Resp1_Valid, Req0_Ready, Req1_Ready}, 11'b11001100000);
    end
    n_checks++;
    if ({Resp0_RxData, Resp1_RxData} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_rxdata: got %h expected 0000", {Resp0_RxData, Resp1_RxData});
    end
    Reset = 1'b0;
    @(negedge FastClk);
    n_checks++;
    if ({nFlashSel, nTFSel, Busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b expected 110", {nFlashSel, nTFSel, Busy});
    end
  endtask

  task automatic test_single_flash();
    logic [7:0] mosi;
    int nbit, resp_cyc, sck_err, tf_err, cs_err;
    logic prev_sck;
    logic [8:0] exp;
    logic [8:0] obs;
    fl_byte = 8'h3C;
    @(negedge FastClk);
    Req0_Valid = 1'b1; Req0_Dev = 1'b0; Req0_TxData = 8'hA5; Req0_Last = 1'b1;
    #1;
    n_checks++;
    if ({Req0_Ready, Req1_Ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_ready: got %b expected 10", {Req0_Ready, Req1_Ready});
    end
    sb.push_back({1'b0, 8'h3C});
    @(posedge FastClk);
    #1 Req0_Valid = 1'b0;
    mosi = 8'h00; nbit = 0; prev_sck = 1'b0; resp_cyc = -1;
    sck_err = 0; tf_err = 0; cs_err = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge FastClk);
      if (nFlashSel !== ((c <= 34) ? 1'b0 : 1'b1)) cs_err++;
      if (SPIClk !== ((c <= 32 && ((c - 1) / 2) % 2 == 1) ? 1'b1 : 1'b0)) sck_err++;
      if (SPIClk && !prev_sck) begin
        mosi = {mosi[6:0], SPIDo};
        nbit++;
      end
      prev_sck = SPIClk;
      if ({nTFSel, TFClk, TFDo} !== 3'b101) tf_err++;
      if (Resp0_Valid || Resp1_Valid) begin
        resp_cyc = c;
        exp = (sb.size() > 0) ? sb.pop_front() : 9'bx;
        obs = {Resp1_Valid, Resp1_Valid ? Resp1_RxData : Resp0_RxData};
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL single_resp_data: got %h expected %h", obs, exp);
        end
      end
    end
    n_checks++;
    if (cs_err !== 0) begin
      n_fail++;
      $display("FAIL single_cs_window: got %0d bad cycles expected 0", cs_err);
    end
    n_checks++;
    if (sck_err !== 0) begin
      n_fail++;
      $display("FAIL single_sck_timing: got %0d bad cycles expected 0", sck_err);
    end
    n_checks++;
    if (resp_cyc !== 33) begin
      n_fail++;
      $display("FAIL single_resp_cycle: got %0d expected 33", resp_cyc);
    end
    n_checks++;
    if ({nbit[3:0], mosi} !== {4'd8, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_mosi: got %0d bits %h expected 8 bits a5", nbit, mosi);
    end
    n_checks++;
    if (tf_err !== 0) begin
      n_fail++;
      $display("FAIL single_tf_idle: got %0d bad cycles expected 0", tf_err);
    end
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_end: got %b expected 0", Busy);
    end
  endtask

  task automatic test_arbitration();
    int r1_cyc;
    bit got;
    int cyc;
    logic [8:0] obs, exp;
    Reset = 1'b1;
    @(negedge FastClk);
    Reset = 1'b0;
    fl_byte = 8'h3C; tf_byte = 8'h5A;
    Req0_Valid = 1'b1; Req0_Dev = 1'b0; Req0_TxData = 8'h11; Req0_Last = 1'b1;
    Req1_Valid = 1'b1; Req1_Dev = 1'b1; Req1_TxData = 8'h22; Req1_Last = 1'b1;
    #1;
    n_checks++;
    if ({Req0_Ready, Req1_Ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL arb_first_grant: got %b expected 10", {Req0_Ready, Req1_Ready});
    end
    sb.push_back({1'b0, 8'h3C});
    @(posedge FastClk);
    #1 Req0_Valid = 1'b0;
    r1_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge FastClk);
      if (Resp0_Valid || Resp1_Valid) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 9'bx;
        obs = {Resp1_Valid, Resp1_Valid ? Resp1_RxData : Resp0_RxData};
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL arb_resp0: got %h expected %h", obs, exp);
        end
      end
      if (Req1_Ready) begin
        r1_cyc = c;
        break;
      end
    end
    n_checks++;
    if (r1_cyc !== 37) begin
      n_fail++;
      $display("FAIL arb_second_grant_cycle: got %0d expected 37", r1_cyc);
    end
    sb.push_back({1'b1, 8'h5A});
    @(posedge FastClk);
    #1 Req1_Valid = 1'b0;
    wait_resp(60, got, obs, cyc);
    exp = (sb.size() > 0) ? sb.pop_front() : 9'bx;
    n_checks++;
    if (!got || obs !== exp || cyc != 33) begin
      n_fail++;
      $display("FAIL arb_resp1: got %h at cycle %0d expected %h at 33", obs, cyc, exp);
    end
    repeat (6) @(negedge FastClk);
    Req0_Valid = 1'b1; Req0_TxData = 8'h33;
    Req1_Valid = 1'b1; Req1_TxData = 8'h44;
    #1;
    n_checks++;
    if ({Req0_Ready, Req1_Ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL arb_alternate: got %b expected 10", {Req0_Ready, Req1_Ready});
    end
    sb.push_back({1'b0, 8'h3C});
    @(posedge FastClk);
    #1 Req0_Valid = 1'b0; Req1_Valid = 1'b0;
    wait_resp(60, got, obs, cyc);
    exp = (sb.size() > 0) ? sb.pop_front() : 9'bx;
    n_checks++;
    if (!got || obs !== exp) begin
      n_fail++;
      $display("FAIL arb_resp_alt: got %h expected %h", obs, exp);
    end
    repeat (6) @(negedge FastClk);
  endtask

  task automatic test_burst();
    int sent, low_cnt, r0_cyc;
    bit got;
    int cyc;
    logic [8:0] obs, exp;
    tf_byte = 8'h5A; fl_byte = 8'h96;
    @(negedge FastClk);
    Req1_Valid = 1'b1; Req1_Dev = 1'b1; Req1_TxData = 8'h01; Req1_Last = 1'b0;
    Req0_Valid = 1'b1; Req0_Dev = 1'b0; Req0_TxData = 8'h77; Req0_Last = 1'b1;
    #1;
    n_checks++;
    if ({Req0_Ready, Req1_Ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL burst_first_grant: got %b expected 01", {Req0_Ready, Req1_Ready});
    end
    sb.push_back({1'b1, 8'h5A});
    @(posedge FastClk);
    #1 Req1_TxData = 8'h02;
    sent = 1; low_cnt = 0; r0_cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge FastClk);
      if (!nTFSel) low_cnt++;
      if (Resp0_Valid || Resp1_Valid) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 9'bx;
        obs = {Resp1_Valid, Resp1_Valid ? Resp1_RxData : Resp0_RxData};
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL burst_resp: got %h expected %h", obs, exp);
        end
      end
      if (Req0_Ready) begin
        r0_cyc = c;
        break;
      end
      if (Req1_Valid && Req1_Ready) begin
        sent++;
        sb.push_back({1'b1, (sent == 2) ? 8'h6B : 8'h7C});
        @(posedge FastClk);
        #1;
        if (sent == 2) begin
          Req1_TxData = 8'h03;
          Req1_Last   = 1'b1;
          Req1_Dev    = 1'b0;  // must be ignored mid-transaction
        end else begin
          Req1_Valid = 1'b0;
        end
      end
    end
    n_checks++;
    if (sent !== 3) begin
      n_fail++;
      $display("FAIL burst_bytes_sent: got %0d expected 3", sent);
    end
    n_checks++;
    if (low_cnt !== 100) begin
      n_fail++;
      $display("FAIL burst_cs_low_cycles: got %0d expected 100", low_cnt);
    end
    n_checks++;
    if (r0_cyc !== 103) begin
      n_fail++;
      $display("FAIL burst_req0_grant_cycle: got %0d expected 103", r0_cyc);
    end
    sb.push_back({1'b0, 8'h96});
    @(posedge FastClk);
    #1 Req0_Valid = 1'b0;
    wait_resp(60, got, obs, cyc);
    exp = (sb.size() > 0) ? sb.pop_front() : 9'bx;
    n_checks++;
    if (!got || obs !== exp) begin
      n_fail++;
      $display("FAIL burst_req0_resp: got %h expected %h", obs, exp);
    end
    repeat (6) @(negedge FastClk);
  endtask

  task automatic test_hold_stall();
    int err, r0_cyc;
    bit got;
    int cyc;
    logic [8:0] obs, exp;
    tf_byte = 8'h5A; fl_byte = 8'h0F;
    @(negedge FastClk);
    Req1_Valid = 1'b1; Req1_Dev = 1'b1; Req1_TxData = 8'hF0; Req1_Last = 1'b0;
    #1;
    n_checks++;
    if ({Req0_Ready, Req1_Ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_grant: got %b expected 01", {Req0_Ready, Req1_Ready});
    end
    sb.push_back({1'b1, 8'h5A});
    @(posedge FastClk);
    #1;
    Req1_Valid = 1'b0;
    Req0_Valid = 1'b1; Req0_Dev = 1'b0; Req0_TxData = 8'h0F; Req0_Last = 1'b1;
    wait_resp(60, got, obs, cyc);
    exp = (sb.size() > 0) ? sb.pop_front() : 9'bx;
    n_checks++;
    if (!got || obs !== exp || cyc != 33) begin
      n_fail++;
      $display("FAIL hold_resp: got %h at cycle %0d expected %h at 33", obs, cyc, exp);
    end
    err = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge FastClk);
      if ({nTFSel, TFClk, Busy, Req0_Ready, Resp0_Valid, nFlashSel} !== 6'b001001) err++;
    end
    n_checks++;
    if (err !== 0) begin
      n_fail++;
      $display("FAIL hold_stall_state: got %0d bad cycles expected 0", err);
    end
    Req1_Valid = 1'b1; Req1_TxData = 8'hE1; Req1_Last = 1'b1;
    #1;
    n_checks++;
    if ({Req0_Ready, Req1_Ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_resume_ready: got %b expected 01", {Req0_Ready, Req1_Ready});
    end
    sb.push_back({1'b1, 8'h6B});
    @(posedge FastClk);
    #1 Req1_Valid = 1'b0;
    wait_resp(60, got, obs, cyc);
    exp = (sb.size() > 0) ? sb.pop_front() : 9'bx;
    n_checks++;
    if (!got || obs !== exp) begin
      n_fail++;
      $display("FAIL hold_resume_resp: got %h expected %h", obs, exp);
    end
    r0_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (Req0_Ready) begin
        r0_cyc = c;
        break;
      end
      @(negedge FastClk);
    end
    n_checks++;
    if (r0_cyc < 0) begin
      n_fail++;
      $display("FAIL hold_req0_granted: got no grant expected grant within 20 cycles");
    end
    sb.push_back({1'b0, 8'h0F});
    @(posedge FastClk);
    #1 Req0_Valid = 1'b0;
    wait_resp(60, got, obs, cyc);
    exp = (sb.size() > 0) ? sb.pop_front() : 9'bx;
    n_checks++;
    if (!got || obs !== exp) begin
      n_fail++;
      $display("FAIL hold_req0_resp: got %h expected %h", obs, exp);
    end
    repeat (6) @(negedge FastClk);
  endtask

  task automatic test_reset_mid();
    int resp_cnt;
    bit got;
    int cyc;
    logic [8:0] obs, exp;
    fl_byte = 8'h81;
    @(negedge FastClk);
    Req0_Valid = 1'b1; Req0_Dev = 1'b0; Req0_TxData = 8'h5A; Req0_Last = 1'b1;
    @(posedge FastClk);
    #1 Req0_Valid = 1'b0;
    repeat (16) @(negedge FastClk);  // cycle 16: SCK high during bit 4
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({nFlashSel, SPIClk, Busy, Resp0_Valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL midreset_pins: got %b expected 1000",
               {nFlashSel, SPIClk, Busy, Resp0_Valid});
    end
    repeat (2) @(negedge FastClk);
    Reset = 1'b0;
    resp_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge FastClk);
      if (Resp0_Valid || Resp1_Valid) resp_cnt++;
    end
    n_checks++;
    if (resp_cnt !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_resp: got %0d pulses expected 0", resp_cnt);
    end
    Req0_Valid = 1'b1; Req0_TxData = 8'hC6;
    sb.push_back({1'b0, 8'h81});
    @(posedge FastClk);
    #1 Req0_Valid = 1'b0;
    wait_resp(60, got, obs, cyc);
    exp = (sb.size() > 0) ? sb.pop_front() : 9'bx;
    n_checks++;
    if (!got || obs !== exp || cyc != 33) begin
      n_fail++;
      $display("FAIL midreset_rerun: got %h at cycle %0d expected %h at 33", obs, cyc, exp);
    end
    repeat (6) @(negedge FastClk);
  endtask

  task automatic test_clkdiv1();
    logic [7:0] mosi;
    int resp_cyc, sck_err, cs_low;
    logic prev_sck;
    logic [8:0] exp;
    d1_byte = 8'hC3;
    @(negedge FastClk);
    d1_Req0_Valid = 1'b1; d1_Req0_TxData = 8'h5C;
    #1;
    n_checks++;
    if (d1_Req0_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL div1_ready: got %b expected 1", d1_Req0_Ready);
    end
    sb.push_back({1'b0, 8'hC3});
    @(posedge FastClk);
    #1 d1_Req0_Valid = 1'b0;
    mosi = 8'h00; resp_cyc = -1; sck_err = 0; cs_low = 0; prev_sck = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge FastClk);
      if (d1_SPIClk !== ((c <= 16 && c % 2 == 0) ? 1'b1 : 1'b0)) sck_err++;
      if (d1_SPIClk && !prev_sck) mosi = {mosi[6:0], d1_SPIDo};
      prev_sck = d1_SPIClk;
      if (!d1_nFlashSel) cs_low++;
      if (d1_Resp0_Valid) begin
        resp_cyc = c;
        exp = (sb.size() > 0) ? sb.pop_front() : 9'bx;
        n_checks++;
        if ({1'b0, d1_Resp0_RxData} !== exp) begin
          n_fail++;
          $display("FAIL div1_resp_data: got %h expected %h", d1_Resp0_RxData, exp);
        end
      end
    end
    n_checks++;
    if (resp_cyc !== 17) begin
      n_fail++;
      $display("FAIL div1_resp_cycle: got %0d expected 17", resp_cyc);
    end
    n_checks++;
    if (sck_err !== 0) begin
      n_fail++;
      $display("FAIL div1_sck_period: got %0d bad cycles expected 0", sck_err);
    end
    n_checks++;
    if ({mosi, cs_low[7:0]} !== {8'h5C, 8'd17}) begin
      n_fail++;
      $display("FAIL div1_mosi_cs: got %h/%0d expected 5c/17", mosi, cs_low);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_flash();
    test_arbitration();
    test_burst();
    test_hold_stall();
    test_reset_mid();
    test_clkdiv1();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
